// File: rtl/fp_acc_if.sv
// Valid/ready bus between the FP multiplier stream and fp_accumulator.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface fp_acc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/fp_accumulator.sv
// Multi-cycle FP32 accumulator (align / add / normalise, truncating, flush-to-zero).
// Optional macro FP_ACC_SATURATE_EN: overflow saturates to +-max finite and sets a sticky flag.
module fp_accumulator #(
    parameter int GUARD_BITS   = 3,
    parameter bit CLEAR_ON_OUT = 1'b1
) (
    input logic    clk,
    input logic    rst_n,
    fp_acc_if.slave bus
);
    localparam int          W  = 24 + GUARD_BITS;
    localparam logic [7:0]  W8 = 8'(W);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t        state;
    logic [31:0]   acc, term_q, out_data_q;
    logic          last_q, in_ready_q, busy_q, out_valid_q;
    logic          big_sign, sub_q, sum_sign;
    logic [7:0]    big_exp, sum_exp;
    logic [W-1:0]  big_mant, small_mant;
    logic [W:0]    sum_q;
`ifdef FP_ACC_SATURATE_EN
    logic          sat_flag;
`endif

    // Align: pick the larger magnitude (exp-0 operands count as zero) and shift the other.
    logic [31:0]   big, sml;
    logic [30:0]   a_mag, b_mag;
    logic [W-1:0]  mant_big, mant_sml, shifted;
    logic [7:0]    shamt;

    // NOTE: every variable gets a default at the top of the always_comb, so no path can infer a latch.
    always_comb begin
        a_mag    = (acc[30:23] == 8'd0) ? 31'd0 : acc[30:0];
        b_mag    = (term_q[30:23] == 8'd0) ? 31'd0 : term_q[30:0];
        big      = (b_mag > a_mag) ? term_q : acc;
        sml      = (b_mag > a_mag) ? acc : term_q;
        mant_big = (big[30:23] == 8'd0) ? '0 : {1'b1, big[22:0], {GUARD_BITS{1'b0}}};
        mant_sml = (sml[30:23] == 8'd0) ? '0 : {1'b1, sml[22:0], {GUARD_BITS{1'b0}}};
        shamt    = big[30:23] - sml[30:23];
        shifted  = (shamt >= W8) ? '0 : (mant_sml >> shamt);
    end

    logic [W:0] sum_c;
    assign sum_c = sub_q ? ({1'b0, big_mant} - {1'b0, small_mant})
                         : ({1'b0, big_mant} + {1'b0, small_mant});

    // Normalise: single-cycle leading-zero count, then pack with truncation.
    logic [7:0]        lz;
    logic              found;
    logic [W-1:0]      mant_n;
    logic signed [9:0] exp_n;
    logic [22:0]       frac;
    logic [31:0]       result;
    logic              ovf;
    logic              unused_bits;

    always_comb begin
        lz    = 8'd0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum_q[i]) found = 1'b1;
                else          lz    = lz + 8'd1;
            end
        end
        if (sum_q[W]) begin
            mant_n = sum_q[W:1];
            exp_n  = $signed({2'b00, sum_exp}) + 10'sd1;
        end else begin
            mant_n = sum_q[W-1:0] << lz;
            exp_n  = $signed({2'b00, sum_exp}) - $signed({2'b00, lz});
        end
        frac = mant_n[W-2:GUARD_BITS];
        ovf  = 1'b0;
        if (sum_q == '0 || exp_n < 10'sd1) begin
            result = 32'h0000_0000;
        end else if (exp_n > 10'sd254) begin
            ovf = 1'b1;
`ifdef FP_ACC_SATURATE_EN
            result = {sum_sign, 8'hFE, 23'h7F_FFFF};
`else
            result = {sum_sign, exp_n[7:0], frac};
`endif
        end else begin
            result = {sum_sign, exp_n[7:0], frac};
        end
    end

    // Hidden bit and guard bits are dropped when packing.
    assign unused_bits = ^{mant_n[W-1], mant_n[GUARD_BITS-1:0], ovf};

    // NOTE: all state below uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= 32'h0;
            term_q      <= 32'h0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            big_sign    <= 1'b0;
            big_exp     <= 8'h0;
            big_mant    <= '0;
            small_mant  <= '0;
            sub_q       <= 1'b0;
            sum_q       <= '0;
            sum_sign    <= 1'b0;
            sum_exp     <= 8'h0;
`ifdef FP_ACC_SATURATE_EN
            sat_flag    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        term_q     <= bus.in_data;
                        last_q     <= bus.in_last;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    big_sign   <= big[31];
                    big_exp    <= big[30:23];
                    big_mant   <= mant_big;
                    small_mant <= shifted;
                    sub_q      <= big[31] ^ sml[31];
                    state      <= S_ADD;
                end
                S_ADD: begin
                    sum_q    <= sum_c;
                    sum_sign <= big_sign;
                    sum_exp  <= big_exp;
                    state    <= S_NORM;
                end
                S_NORM: begin
                    acc <= result;
`ifdef FP_ACC_SATURATE_EN
                    sat_flag <= sat_flag | ovf;
`endif
                    if (last_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= result;
                        state       <= S_DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                        if (CLEAR_ON_OUT) acc <= 32'h0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fp_accumulator.sv
// Directed-vector bench for fp_accumulator with hand-computed FP32 expectations.
// Overflow expectation follows FP_ACC_SATURATE_EN.
module tb_fp_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    fp_acc_if bus ();

    fp_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Waits (bounded) for in_ready, then presents one term for one accept edge.
    task automatic send(input logic [31:0] data, input logic last);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready: in_ready=%b after %0d cycles, want 1", bus.in_ready, n);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Waits (bounded) for out_valid, captures out_data, then takes it with a one-cycle out_ready.
    task automatic take_result(output logic [31:0] data, output int lat, output bit ok);
        lat  = 0;
        ok   = 1'b0;
        data = 'x;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (ok) begin
            data = bus.out_data;
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] d, output bit ok);
        int lat;
        send(a, 1'b0);
        send(b, 1'b1);
        take_result(d, lat, ok);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h, want 1 0 0 00000000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sum();
        logic [31:0] d;
        int          lat;
        bit          ok;
        send(32'h3F80_0000, 1'b0);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_busy: in_ready=%b busy=%b, want 0 1", bus.in_ready, bus.busy);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_early: in_ready=%b 3 cycles after accept, want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_return: in_ready=%b busy=%b 4 cycles after accept, want 1 0",
                     bus.in_ready, bus.busy);
        end
        send(32'h4000_0000, 1'b1);
        take_result(d, lat, ok);
        vectors++;
        if (!ok || lat != 3) begin
            miscompares++;
            $display("FAIL sum_latency: ok=%0b latency=%0d, want 1 3", ok, lat);
        end
        vectors++;
        if (d !== 32'h4040_0000) begin
            miscompares++;
            $display("FAIL sum_1p2: got %h, want 40400000", d);
        end
    endtask

    task automatic test_arith();
        logic [31:0] d;
        bit          ok;
        logic [31:0] vec [6][3] = '{
            '{32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000},  // equal magnitude cancel
            '{32'h4040_0000, 32'hBF80_0000, 32'h4000_0000},  // 3 - 1
            '{32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000},  // 1 - 2, negative result
            '{32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000},  // 1 lands in guard bits, truncated
            '{32'h4D80_0000, 32'h3F80_0000, 32'h4D80_0000},  // shift beyond mantissa width
            '{32'h00C0_0000, 32'h8080_0000, 32'h0000_0000}   // exponent underflow
        };
        for (int i = 0; i < 6; i++) begin
            run_pair(vec[i][0], vec[i][1], d, ok);
            vectors++;
            if (!ok || d !== vec[i][2]) begin
                miscompares++;
                $display("FAIL arith_%0d: %h + %h got %h (ok=%0b), want %h",
                         i, vec[i][0], vec[i][1], d, ok, vec[i][2]);
            end
        end
    endtask

    task automatic test_zero();
        logic [31:0] d;
        int          lat;
        bit          ok;
        send(32'h0000_0000, 1'b1);
        take_result(d, lat, ok);
        vectors++;
        if (!ok || d !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_term: got %h (ok=%0b), want 00000000", d, ok);
        end
        send(32'h0040_0000, 1'b1);
        take_result(d, lat, ok);
        vectors++;
        if (!ok || d !== 32'h0) begin
            miscompares++;
            $display("FAIL ftz_term: got %h (ok=%0b), want 00000000", d, ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int          lat;
        bit          ok;
        for (int i = 0; i < 4; i++) send(32'h3F80_0000, (i == 3));
        take_result(d, lat, ok);
        vectors++;
        if (!ok || d !== 32'h4080_0000) begin
            miscompares++;
            $display("FAIL four_ones: got %h (ok=%0b), want 40800000", d, ok);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        int          lat;
        bit          ok;
        int          n = 0;
        send(32'h3F80_0000, 1'b1);
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4000_0000;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F80_0000 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_%0d: out_valid=%b out_data=%h in_ready=%b, want 1 3f800000 0",
                         c, bus.out_valid, bus.out_data, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL taken: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        send(32'h3F80_0000, 1'b1);
        take_result(d, lat, ok);
        vectors++;
        if (!ok || d !== 32'h3F80_0000) begin
            miscompares++;
            $display("FAIL cleared_acc: got %h (ok=%0b), want 3f800000", d, ok);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int          lat;
        bit          ok;
        send(32'h4000_0000, 1'b0);
        send(32'h3F80_0000, 1'b1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset: out_valid=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: in_ready=%b, want 1", bus.in_ready);
        end
        send(32'h3F80_0000, 1'b1);
        take_result(d, lat, ok);
        vectors++;
        if (!ok || d !== 32'h3F80_0000) begin
            miscompares++;
            $display("FAIL midreset_acc: got %h (ok=%0b), want 3f800000", d, ok);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] want;
        bit          ok;
`ifdef FP_ACC_SATURATE_EN
        want = 32'h7F7F_FFFF;
`else
        want = 32'h7F80_0000;
`endif
        run_pair(32'h7F00_0000, 32'h7F00_0000, d, ok);
        vectors++;
        if (!ok || d !== want) begin
            miscompares++;
            $display("FAIL overflow: got %h (ok=%0b), want %h", d, ok, want);
        end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_arith();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
